// File: rtl/therm_pkg.sv
// Shared types and constants for the thermal sensor frequency-measurement path.
package therm_pkg;

  // Measurement controller states.
  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StPublish
  } state_e;

  // Flops in the oscillator-tap synchronizer chain.
  localparam int unsigned SyncDepth = 2;

  // 1 ms gate at 100 MHz.
  localparam int unsigned DefaultGate = 100000;

  // Largest value the result byte can carry.
  localparam logic [7:0] ByteMax = 8'hFF;

endpackage

// File: rtl/sync_edge.sv
// Synchronizes an asynchronous level into clk and emits a one-cycle pulse per rising edge.
module sync_edge
  import therm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic [SyncDepth-1:0] sync_q;
  logic                 prev_q;

  // Shift the raw input through the synchronizer and keep the previous synced level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncDepth-2:0], async_in};
      prev_q <= sync_q[SyncDepth-1];
    end
  end

  assign pulse = sync_q[SyncDepth-1] & ~prev_q;

endmodule

// File: rtl/freq_counter.sv
// Gated frequency counter: counts ring-oscillator edges over a fixed window, then scales,
// saturates to a byte and offers the result on a valid/ready handshake.
module freq_counter
  import therm_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DefaultGate,  // must be >= 2
  parameter int unsigned SHIFT       = 4,
  parameter int unsigned CNT_W       = 24            // must exceed 8 for the saturation test
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ro_in,
  input  logic       preset_en,
  input  logic [7:0] preset_val,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       overflow
);

  localparam int unsigned GateW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);

  state_e             state_q;
  logic [GateW-1:0]   gate_q;
  logic [CNT_W-1:0]   edge_q;
  logic [7:0]         data_q;
  logic               valid_q;
  logic               overflow_q;

  logic               ro_pulse;
  logic [CNT_W-1:0]   edge_inc;
  logic [CNT_W-1:0]   scaled;
  logic               scaled_over;
  logic [7:0]         scaled_byte;

  sync_edge u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .async_in (ro_in),
    .pulse    (ro_pulse)
  );

  // Edge count including this cycle's pulse (saturating), and its scaled/saturated byte form.
  always_comb begin
    edge_inc = edge_q;
    if (ro_pulse && (edge_q != {CNT_W{1'b1}})) begin
      edge_inc = edge_q + 1'b1;
    end
    scaled      = edge_inc >> SHIFT;
    scaled_over = |scaled[CNT_W-1:8];
    scaled_byte = scaled_over ? ByteMax : scaled[7:0];
  end

  // Measurement FSM with gate/edge counters and registered result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      gate_q     <= '0;
      edge_q     <= '0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          gate_q <= '0;
          edge_q <= '0;
          if (en) begin
            state_q <= StCount;
          end
        end
        StCount: begin
          if (!en) begin
            // Abort: the partial window is discarded.
            state_q <= StIdle;
            gate_q  <= '0;
            edge_q  <= '0;
          end else if (gate_q == GateLast) begin
            // preset_en only matters in this capture cycle.
            data_q     <= preset_en ? preset_val : scaled_byte;
            overflow_q <= ~preset_en & scaled_over;
            valid_q    <= 1'b1;
            state_q    <= StPublish;
            gate_q     <= '0;
            edge_q     <= '0;
          end else begin
            gate_q <= gate_q + 1'b1;
            edge_q <= edge_inc;
          end
        end
        StPublish: begin
          // Result is held until taken; en alone never retracts it.
          if (ready) begin
            valid_q <= 1'b0;
            state_q <= en ? StCount : StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign data     = data_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_freq_counter.sv
// Directed bench for freq_counter with a 1000-cycle gate; a second instance uses SHIFT=4.
module tb_freq_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       ro_in;
  logic       preset_en;
  logic [7:0] preset_val;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       overflow;
  logic [7:0] data4;
  logic       valid4;
  logic       overflow4;

  int checks;
  int errors;
  int ro_half;

  freq_counter #(
    .GATE_CYCLES (1000),
    .SHIFT       (0),
    .CNT_W       (24)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ro_in      (ro_in),
    .preset_en  (preset_en),
    .preset_val (preset_val),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .overflow   (overflow)
  );

  freq_counter #(
    .GATE_CYCLES (1000),
    .SHIFT       (4),
    .CNT_W       (24)
  ) dut4 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ro_in      (ro_in),
    .preset_en  (preset_en),
    .preset_val (preset_val),
    .data       (data4),
    .valid      (valid4),
    .ready      (ready),
    .overflow   (overflow4)
  );

  // 100 MHz clock, rising edges at 5 + 10k ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Oscillator tap; toggles sit 3 ns after a 10 ns grid so they never meet a clock edge.
  initial begin
    ro_in = 1'b0;
    #3;
    forever begin
      if (ro_half == 0) begin
        ro_in = 1'b0;
        #10;
      end else begin
        #(ro_half) ro_in = ~ro_in;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts falling edges until valid is seen; n = -1 on timeout.
  task automatic wait_valid(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  int   n;
  logic [7:0] d0;
  logic stable;
  logic quiet;

  initial begin
    checks     = 0;
    errors     = 0;
    ro_half    = 0;
    rst        = 1'b0;
    en         = 1'b0;
    preset_en  = 1'b0;
    preset_val = 8'h00;
    ready      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'h00);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal: 80 ns period, 8 clk cycles per edge -> 125 edges per window
    ro_half = 40;
    ready   = 1'b1;
    en      = 1'b1;
    wait_valid(2000, n);
    check("nom1_latency", 32'(n), 32'd1001);
    check("nom1_data", 32'(data >= 8'd124 && data <= 8'd126), 32'd1);
    check("nom1_overflow", 32'(overflow), 32'd0);
    wait_valid(2000, n);
    check("nom2_period", 32'(n), 32'd1001);
    check("nom2_data", 32'(data >= 8'd124 && data <= 8'd126), 32'd1);
    check("nom2_overflow", 32'(overflow), 32'd0);

    // Transfer with en=0 returns to IDLE; switch to 20 ns period while idle
    en = 1'b0;
    @(negedge clk);
    check("idle_valid", 32'(valid), 32'd0);
    ro_half = 10;
    repeat (10) @(negedge clk);
    en = 1'b1;
    wait_valid(2000, n);
    check("sat_latency", 32'(n), 32'd1001);
    check("sat_data", 32'(data), 32'hFF);
    check("sat_overflow", 32'(overflow), 32'd1);
    check("shift4_valid", 32'(valid4), 32'd1);
    check("shift4_data", 32'(data4), 32'h1F);
    check("shift4_overflow", 32'(overflow4), 32'd0);

    // Preset overrides the (saturated) measurement on both instances
    preset_en  = 1'b1;
    preset_val = 8'hA5;
    wait_valid(2000, n);
    check("pre1_period", 32'(n), 32'd1001);
    check("pre1_data", 32'(data), 32'hA5);
    check("pre1_overflow", 32'(overflow), 32'd0);
    check("pre1_data4", 32'(data4), 32'hA5);
    wait_valid(2000, n);
    check("pre2_data", 32'(data), 32'hA5);
    check("pre2_overflow", 32'(overflow), 32'd0);

    // Backpressure: take this result, then hold ready low for the next one
    preset_en = 1'b0;
    ro_half   = 40;
    @(negedge clk);
    ready = 1'b0;
    wait_valid(2000, n);
    check("bp_latency", 32'(n), 32'd1000);
    d0     = data;
    stable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (valid !== 1'b1 || data !== d0) stable = 1'b0;
    end
    check("bp_hold", 32'(stable), 32'd1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("bp_drop", 32'(valid), 32'd0);
    wait_valid(2000, n);
    check("bp_next", 32'(n), 32'd1000);
    check("bp_next_data", 32'(data >= 8'd124 && data <= 8'd126), 32'd1);
    repeat (5) @(negedge clk);
    check("bp_next_held", 32'(valid), 32'd1);

    // Abort at gate cycle ~500: no result until en returns
    ready = 1'b1;
    repeat (500) @(negedge clk);
    en    = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (valid !== 1'b0) quiet = 1'b0;
    end
    check("abort_quiet", 32'(quiet), 32'd1);
    en = 1'b1;
    wait_valid(2000, n);
    check("abort_restart", 32'(n), 32'd1001);
    check("abort_data", 32'(data >= 8'd124 && data <= 8'd126), 32'd1);

    // Asynchronous reset mid-COUNT clears outputs before the next clock edge
    repeat (300) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_data", 32'(data), 32'h00);
    check("arst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_valid(2000, n);
    check("arst_first", 32'(n), 32'd1001);
    check("arst_result", 32'(data >= 8'd124 && data <= 8'd126), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
